// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the instruction memory slice.
// Contents: icode constants, maximum instruction length, the imem FSM state
// type and an even-parity helper.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam int unsigned INSTR_MAX_BYTES = 10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

  // Parity bit that makes the 9-bit {parity, byte} word carry an even number of ones.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/imem_window_read.sv
// Combinational extraction of a 10-byte instruction window from the flat
// memory image.
// Ports:
//   mem_bytes  flat memory image, byte i in [8i+7:8i]
//   addr       window start address (full 64 bits)
//   win_bytes  window, byte at addr+k in [8k+7:8k]; zero when out of range
//   win_err    addr >= MEM_BYTES
//   mem_par    (IMEM_PARITY_EN) stored even-parity bit per byte
//   win_perr   (IMEM_PARITY_EN) parity mismatch on any in-range window byte
// Optional feature macro: IMEM_PARITY_EN.
module imem_window_read
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic [MEM_BYTES*8-1:0]         mem_bytes,
  input  logic [63:0]                    addr,
  output logic [INSTR_MAX_BYTES*8-1:0]   win_bytes,
  output logic                           win_err
`ifdef IMEM_PARITY_EN
  ,
  input  logic [MEM_BYTES-1:0]           mem_par,
  output logic                           win_perr
`endif
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  logic [63:0]   byte_addr;
  logic [AW+2:0] bit_idx;

  always_comb begin
    win_bytes = '0;
    win_err   = (addr >= 64'(MEM_BYTES));
    byte_addr = '0;
    bit_idx   = '0;
`ifdef IMEM_PARITY_EN
    win_perr  = 1'b0;
`endif
    for (int unsigned k = 0; k < INSTR_MAX_BYTES; k++) begin
      // 64-bit sum cannot wrap for in-range addr, so the compare is exact.
      byte_addr = addr + 64'(k);
      bit_idx   = {byte_addr[AW-1:0], 3'b000};
      if (!win_err && (byte_addr < 64'(MEM_BYTES))) begin
        win_bytes[k*8 +: 8] = mem_bytes[bit_idx +: 8];
`ifdef IMEM_PARITY_EN
        if (even_parity(mem_bytes[bit_idx +: 8]) != mem_par[byte_addr[AW-1:0]])
          win_perr = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/imem_server.sv
// Byte-addressed Y86-64 instruction memory, responder side of the fetch
// interface. A request snapshots a 10-byte window at acceptance and returns it
// with fetch_ack exactly READ_LAT cycles later.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   fetch_req/addr    fetch request (held until ack) and PC
//   fetch_busy        high from acceptance through the ack cycle
//   fetch_ack         one-cycle response strobe
//   fetch_bytes       instruction window (holds value between acks)
//   imem_error        PC >= MEM_BYTES, valid with fetch_ack
//   prog_we/addr/data program-load byte write port
//   prog_perr_inject  (IMEM_PARITY_EN) invert stored parity on write
//   fetch_perr        (IMEM_PARITY_EN) window parity error, valid with ack
// Optional feature macro: IMEM_PARITY_EN.
module imem_server
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned READ_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [63:0] fetch_addr,
  output logic        fetch_busy,
  output logic        fetch_ack,
  output logic [79:0] fetch_bytes,
  output logic        imem_error,
  input  logic        prog_we,
  input  logic [63:0] prog_addr,
  input  logic [7:0]  prog_data
`ifdef IMEM_PARITY_EN
  ,
  input  logic        prog_perr_inject,
  output logic        fetch_perr
`endif
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [MEM_BYTES*8-1:0] mem_q;
  imem_state_t            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   accept;
  logic [79:0]            hold_bytes_q, win_bytes;
  logic                   hold_err_q, win_err;
  logic                   prog_hit;

  assign prog_hit = prog_we && (prog_addr < 64'(MEM_BYTES));

`ifdef IMEM_PARITY_EN
  logic [MEM_BYTES-1:0] par_q;
  logic                 hold_perr_q, win_perr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
`ifdef IMEM_PARITY_EN
      par_q <= '0;
`endif
    end else if (prog_hit) begin
      mem_q[{prog_addr[AW-1:0], 3'b000} +: 8] <= prog_data;
`ifdef IMEM_PARITY_EN
      par_q[prog_addr[AW-1:0]] <= even_parity(prog_data) ^ prog_perr_inject;
`endif
    end
  end

  // Reads the pre-write image, so a same-cycle write is not seen by the fetch.
  imem_window_read #(
    .MEM_BYTES(MEM_BYTES)
  ) u_window (
    .mem_bytes (mem_q),
    .addr      (fetch_addr),
    .win_bytes (win_bytes),
    .win_err   (win_err)
`ifdef IMEM_PARITY_EN
    ,
    .mem_par   (par_q),
    .win_perr  (win_perr)
`endif
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          accept  = 1'b1;
          cnt_d   = CW'(READ_LAT - 1);
          state_d = (READ_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_bytes_q <= '0;
      hold_err_q   <= 1'b0;
`ifdef IMEM_PARITY_EN
      hold_perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        hold_bytes_q <= win_bytes;
        hold_err_q   <= win_err;
`ifdef IMEM_PARITY_EN
        hold_perr_q  <= win_perr;
`endif
      end
    end
  end

  assign fetch_ack   = (state_q == RESP);
  assign fetch_busy  = (state_q != IDLE);
  assign fetch_bytes = hold_bytes_q;
  assign imem_error  = hold_err_q;
`ifdef IMEM_PARITY_EN
  assign fetch_perr  = hold_perr_q;
`endif

endmodule
